// File: rtl/aunit_acc_pkg.sv
// Shared types for the accumulating PE arithmetic unit: operating modes,
// the per-group control word and the accumulator FSM states.
package aunit_acc_pkg;

    localparam int AuAccLenWd = 8;

    typedef enum logic [2:0] {
        XNOR = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M4   = 3'd3,
        M8   = 3'd4
    } AuMode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } AuAccSt;

    // iNumT/wNumT: 1 = operand lanes are signed, 0 = unsigned
    typedef struct packed {
        logic  work;
        AuMode mode;
        logic  iNumT;
        logic  wNumT;
    } AuCtl;

endpackage

// File: rtl/aunit_acc_if.sv
// Pixel/weight input handshakes and the result port of aunit_acc, bundled so
// the producer side (master) and the arithmetic unit (slave) share one port.
interface aunit_acc_if import aunit_acc_pkg::*; #(
    parameter int DWd   = 16,
    parameter int ODWd  = 24,
    parameter int LenWd = AuAccLenWd
);
    AuCtl                    i_cont;
    logic [LenWd-1:0]        i_acc_len;
    logic [DWd-1:0]          i_ipix;
    logic                    i_ipix_rdy;
    logic                    i_ipix_zero;
    logic                    o_ipix_ack;
    logic [DWd-1:0]          i_wpix;
    logic                    i_wpix_rdy;
    logic                    i_wpix_zero;
    logic                    o_wpix_ack;
    logic signed [ODWd-1:0]  o_sum;
    logic                    o_sum_rdy;
    logic                    o_sum_zero;
    logic                    i_sum_ack;
    logic                    o_ovf;

    modport master (
        output i_cont, i_acc_len,
        output i_ipix, i_ipix_rdy, i_ipix_zero,
        output i_wpix, i_wpix_rdy, i_wpix_zero,
        output i_sum_ack,
        input  o_ipix_ack, o_wpix_ack, o_sum, o_sum_rdy, o_sum_zero, o_ovf
    );

    modport slave (
        input  i_cont, i_acc_len,
        input  i_ipix, i_ipix_rdy, i_ipix_zero,
        input  i_wpix, i_wpix_rdy, i_wpix_zero,
        input  i_sum_ack,
        output o_ipix_ack, o_wpix_ack, o_sum, o_sum_rdy, o_sum_zero, o_ovf
    );
endinterface

// File: rtl/aunit_acc_dot.sv
// Combinational precision-scalable dot product of one packed ipix/wpix word
// pair; lanes are taken from bit 0 upward.
module au_dot import aunit_acc_pkg::*; #(
    parameter int DWd  = 16,
    parameter int DotW = $clog2(DWd) + 17
) (
    input  AuMode                  mode_i,
    input  logic                   inumt_i,
    input  logic                   wnumt_i,
    input  logic [DWd-1:0]         ipix_i,
    input  logic [DWd-1:0]         wpix_i,
    output logic signed [DotW-1:0] dot_o
);

    // Widen a w-bit lane to int, two's-complement when sgn is set.
    function automatic int lane_val(input logic [7:0] bits, input int w, input logic sgn);
        int v;
        v = int'({24'd0, bits}) & ((1 << w) - 1);
        if (sgn && v[w-1]) v = v - (1 << w);
        return v;
    endfunction

    int sum_s;

    always_comb begin
        sum_s = 0;
        case (mode_i)
            XNOR: sum_s = 2 * $countones(~(ipix_i ^ wpix_i)) - DWd;
            M1: begin
                sum_s = $countones(ipix_i & wpix_i);
                if (inumt_i != wnumt_i) sum_s = -sum_s;
            end
            M2: for (int l = 0; l < DWd / 2; l++)
                sum_s += lane_val(8'(ipix_i[2*l +: 2]), 2, inumt_i)
                       * lane_val(8'(wpix_i[2*l +: 2]), 2, wnumt_i);
            M4: for (int l = 0; l < DWd / 4; l++)
                sum_s += lane_val(8'(ipix_i[4*l +: 4]), 4, inumt_i)
                       * lane_val(8'(wpix_i[4*l +: 4]), 4, wnumt_i);
            M8: for (int l = 0; l < DWd / 8; l++)
                sum_s += lane_val(ipix_i[8*l +: 8], 8, inumt_i)
                       * lane_val(wpix_i[8*l +: 8], 8, wnumt_i);
            default: sum_s = 0;
        endcase
        dot_o = DotW'(sum_s);
    end

endmodule

// File: rtl/aunit_acc.sv
// Accumulating PE arithmetic unit: sums acc_len+1 dot-product beats into a
// saturating accumulator and hands the group result out on a rdy/ack port.
module aunit_acc import aunit_acc_pkg::*; #(
    parameter int DWd   = 16,
    parameter int ODWd  = 24,
    parameter int LenWd = AuAccLenWd
) (
    input logic        i_clk,
    input logic        i_rst_n,
    aunit_acc_if.slave au
);

    localparam int DotW = $clog2(DWd) + 17;
    localparam int SumW = ((ODWd > DotW) ? ODWd : DotW) + 1;
    localparam logic signed [SumW-1:0] MaxV = {{(SumW-ODWd+1){1'b0}}, {(ODWd-1){1'b1}}};
    localparam logic signed [SumW-1:0] MinV = {{(SumW-ODWd+1){1'b1}}, {(ODWd-1){1'b0}}};

    function automatic logic signed [ODWd-1:0] sat(input logic signed [SumW-1:0] v);
        if (v > MaxV) return MaxV[ODWd-1:0];
        if (v < MinV) return MinV[ODWd-1:0];
        return v[ODWd-1:0];
    endfunction

    AuAccSt                 st_q, st_d;
    logic signed [ODWd-1:0] acc_q, acc_d;
    logic [LenWd:0]         cnt_q, cnt_d;
    logic [LenWd-1:0]       len_q, len_d;
    AuMode                  mode_q, mode_d;
    logic                   inumt_q, inumt_d, wnumt_q, wnumt_d;
    logic                   zero_q, zero_d, ovf_q, ovf_d;

    logic                   accept, beat, first, last, skip, clamp, new_grp;
    AuMode                  mode_s;
    logic                   inumt_s, wnumt_s;
    logic [DWd-1:0]         ipix_g, wpix_g;
    logic signed [DotW-1:0] dot, dot_eff;
    logic signed [SumW-1:0] base_w, sum_w;

    // In OUT a beat is only taken together with the result ack, so the next
    // group starts with no bubble.
    assign accept  = i_rst_n & au.i_cont.work & ((st_q != OUT) | au.i_sum_ack);
    assign beat    = accept & au.i_ipix_rdy & au.i_wpix_rdy;
    assign new_grp = (st_q != ACC);
    assign first   = beat & new_grp;
    assign last    = new_grp ? (au.i_acc_len == '0) : (cnt_q == {1'b0, len_q});
    assign skip    = au.i_ipix_zero & au.i_wpix_zero;

    assign mode_s  = new_grp ? au.i_cont.mode  : mode_q;
    assign inumt_s = new_grp ? au.i_cont.iNumT : inumt_q;
    assign wnumt_s = new_grp ? au.i_cont.wNumT : wnumt_q;

    // Zero-skipped beats keep the multiplier inputs quiet.
    assign ipix_g = skip ? '0 : au.i_ipix;
    assign wpix_g = skip ? '0 : au.i_wpix;

    au_dot #(.DWd(DWd), .DotW(DotW)) u_dot (
        .mode_i  (mode_s),
        .inumt_i (inumt_s),
        .wnumt_i (wnumt_s),
        .ipix_i  (ipix_g),
        .wpix_i  (wpix_g),
        .dot_o   (dot)
    );

    assign dot_eff = skip ? '0 : dot;
    assign base_w  = first ? '0 : {{(SumW-ODWd){acc_q[ODWd-1]}}, acc_q};
    assign sum_w   = base_w + {{(SumW-DotW){dot_eff[DotW-1]}}, dot_eff};
    assign clamp   = (sum_w > MaxV) || (sum_w < MinV);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) st_q <= IDLE;
        else          st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (beat)
            st_d = last ? OUT : ACC;
        else if (st_q == OUT && au.i_cont.work && au.i_sum_ack)
            st_d = IDLE;
    end

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        inumt_d = inumt_q;
        wnumt_d = wnumt_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        if (beat) begin
            acc_d  = sat(sum_w);
            cnt_d  = first ? {{LenWd{1'b0}}, 1'b1} : cnt_q + 1'b1;
            ovf_d  = clamp | (~first & ovf_q);
            zero_d = skip & (first | zero_q);
            if (first) begin
                len_d   = au.i_acc_len;
                mode_d  = au.i_cont.mode;
                inumt_d = au.i_cont.iNumT;
                wnumt_d = au.i_cont.wNumT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= XNOR;
            inumt_q <= 1'b0;
            wnumt_q <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            inumt_q <= inumt_d;
            wnumt_q <= wnumt_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        au.o_ipix_ack = beat;
        au.o_wpix_ack = beat;
        au.o_sum      = acc_q;
        au.o_sum_rdy  = (st_q == OUT);
        au.o_sum_zero = zero_q;
        au.o_ovf      = ovf_q;
    end

endmodule

// File: doc/aunit_acc.md
Name: aunit_acc

Overview:
- Parametrised successor of the PE arithmetic unit.
- Precision-scalable packed dot product over a DWd-bit ipix/wpix word pair; modes XNOR, M1, M2, M4 and M8, per-operand signedness.
- Accumulates a configurable number of beats into a saturating ODWd accumulator, then presents the result on a rdy/ack output port.
- Sits between the PE pixel buffers (ipix/wpix producers) and the PE partial-sum path.

Parameters:
- DWd, 16, packed operand width in bits; must be a multiple of 8.
- ODWd, 24, accumulator/output width, signed; must be ≥ 12.
- LenWd, 8, width of the accumulation-length field.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_cont  in  AuCtl  fields: work, mode, iNumT, wNumT.
- i_acc_len  in  LenWd  beats per group minus 1.
- i_ipix  in  DWd  packed input pixels.
- i_ipix_rdy  in  1  input pixel word valid.
- i_ipix_zero  in  1  input pixel word is all-zero.
- o_ipix_ack  out  1  input pixel word consumed.
- i_wpix  in  DWd  packed weights.
- i_wpix_rdy  in  1  weight word valid.
- i_wpix_zero  in  1  weight word is all-zero.
- o_wpix_ack  out  1  weight word consumed.
- o_sum  out  ODWd  accumulated result, signed.
- o_sum_rdy  out  1  o_sum valid.
- o_sum_zero  out  1  every beat of the group was zero-skipped.
- i_sum_ack  in  1  result consumed.
- o_ovf  out  1  group saturated (sticky until result acked).

Behaviour:
- Reset: i_rst_n sampled low at a clock edge gives state IDLE, acc=0, cnt=0, o_sum=0, o_sum_rdy=0, o_sum_zero=1, o_ovf=0, acks=0. Reset mid-group discards the partial sum.
- i_cont.work=0: all registers hold; acks forced 0.
- Beat: both rdy high and state accepts. o_ipix_ack = o_wpix_ack = beat (combinational, same cycle). They are never acked separately.
- Group configuration is latched on the first beat of a group: mode, NumT fields, i_acc_len. Changes to these mid-group are ignored.
- FSM:
  - IDLE: on beat, acc=dot and cnt=1. If i_acc_len==0, go to OUT; else go to ACC.
  - ACC: on beat, acc=sat(acc+dot) and cnt++. When cnt==len, go to OUT.
  - OUT: o_sum_rdy=1. o_sum, o_sum_zero and o_ovf are stable while i_sum_ack=0.
    - i_sum_ack=1 with a beat in the same cycle: the beat starts the next group (IDLE-first-beat rules). No bubble.
    - i_sum_ack=1 without a beat: go to IDLE.
- Latency: the result of the last beat appears on o_sum with o_sum_rdy in the next cycle.
- Zero skip: beat with both zero flags high gives dot=0 and no multiplier activity; cnt still increments. o_sum_zero = AND of (ipix_zero & wpix_zero) over all beats of the group.
- Arithmetic, lanes from bit 0 upward:
  - XNOR: dot = 2·popcount(ipix XNOR wpix) − DWd.
  - M1: p = popcount(ipix & wpix). If iNumT≠wNumT, dot = −p; else dot = p.
  - M2/M4/M8: DWd/b lanes, each operand extended per its NumT (signed or unsigned) to b+1 bits, lane products summed at full width.
- Saturation: sat() clamps to [−2^(ODWd−1), 2^(ODWd−1)−1]. A clamp sets o_ovf for the current group. o_ovf clears when the next group starts.
- Accumulator arithmetic is sign-extended to ODWd+1 before clamping.

Decomposition:
- PECtlCfg gains:
  - AuMode enum including M8.
  - AuAccLenWd constant.
  - AuAccSt enum {IDLE, ACC, OUT}.
  - AuCtl struct unchanged.
- Sub-module au_dot: purely combinational DWd-wide dot product (mode, NumT in; signed dot out, width clog2(DWd)+17). Instantiated once; the FSM, counter and accumulator stay in aunit_acc.

Test Plan (DWd=16, ODWd=24 unless stated):
- M4 unsigned, len=0, ipix=0x1234, wpix=0x1111 → next cycle o_sum=10, o_sum_rdy=1, o_sum_zero=0.
- XNOR, len=2, three beats ipix=0xFFFF, wpix=0x0000 → o_sum=−48.
- M8 both signed, len=0, ipix=0x80FF, wpix=0x0102 → o_sum=−130.
- Backpressure: hold i_sum_ack=0 for 5 cycles → o_sum stable and acks low. Then assert i_sum_ack with both rdy high (M2 signed, ipix=wpix=0x5555, len=0) → beat acked that cycle; next o_sum=8.
- Zero skip: len=3, all beats with both zero flags high → o_sum=0, o_sum_zero=1. One non-zero beat → o_sum_zero=0.
- Saturation (ODWd=12), M8 unsigned, ipix=wpix=0xFFFF → o_sum=2047, o_ovf=1. Then assert i_rst_n=0 mid-group of a second group → o_sum_rdy=0, o_ovf=0, o_sum=0 next cycle.
